// File: rtl/rr_mux4_tdm.sv
// rtl/rr_mux4_tdm.sv - 4-to-1 round-robin TDM mux onto one registered output word.
// Optional build macro MUX_FIXED_PRIO_EN selects strict priority ch0 > ch1 > ch2 > ch3.
module rr_mux4_tdm #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       last_grant_q, last_grant_d;

  logic             load_en;
  logic             found;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic [3:0]       grant;

  assign load_en = (state_q == EMPTY) | out_ready;

  always_comb begin
    found     = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    grant     = 4'b0000;
    for (int k = 0; k < 4; k++) begin
`ifdef MUX_FIXED_PRIO_EN
      cand = 2'(k);
`else
      // Search starts one past the previous winner so every lane gets a turn.
      cand = last_grant_q + 2'(k + 1);
`endif
      if (!found && in_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Reset is folded in so no producer sees a handshake while the block is held.
  assign in_ready = grant & {4{load_en & ~rst}};

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (found) begin
        state_d      = FULL;
        out_data_d   = in_data[grant_idx*WIDTH +: WIDTH];
        out_sel_d    = grant_idx;
        last_grant_d = grant_idx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_sel_q    <= 2'd0;
      last_grant_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux4_tdm.sv
// tb/tb_rr_mux4_tdm.sv - directed self-checking bench for rr_mux4_tdm.
module tb_rr_mux4_tdm;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;

  int total;
  int bad;

  rr_mux4_tdm #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++;
    if (out_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++;
    if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", out_sel); end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel [5];
    logic [3:0] exp_dat [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{4'h1, 4'h5, 4'h9, 4'hB, 4'h1};
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== (4'b0001 << exp_sel[i])) begin
        bad++; $display("FAIL rr_in_ready[%0d] got=%b want=%b", i, in_ready, 4'b0001 << exp_sel[i]);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel[i] || out_data !== exp_dat[i]) begin
        bad++;
        $display("FAIL rr_out[%0d] got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                 i, out_valid, out_sel, out_data, exp_sel[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    step();
    total++;
    if (out_sel !== 2'd1 || out_data !== 4'h5) begin
      bad++; $display("FAIL bp_load got sel=%0d data=%h want sel=1 data=5", out_sel, out_data);
    end
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0000", i, in_ready); end
      step();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'h5) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b sel=%0d data=%h want v=1 sel=1 data=5",
                 i, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b want=0100", in_ready); end
    step();
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'h9) begin
      bad++; $display("FAIL bp_release got v=%b sel=%0d data=%h want v=1 sel=2 data=9", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_single_lane();
    in_valid = 4'b0100;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_ready[%0d] got=%b want=0100", i, in_ready); end
      step();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'h9) begin
        bad++;
        $display("FAIL single_out[%0d] got v=%b sel=%0d data=%h want v=1 sel=2 data=9",
                 i, out_valid, out_sel, out_data);
      end
    end
  endtask

  task automatic test_idle_hold();
    in_valid = 4'b1000;
    step();
    total++;
    if (out_sel !== 2'd3 || out_data !== 4'hB || out_valid !== 1'b1) begin
      bad++; $display("FAIL idle_ch3 got v=%b sel=%0d data=%h want v=1 sel=3 data=b", out_valid, out_sel, out_data);
    end
    in_valid = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || out_sel !== 2'd3 || out_data !== 4'hB) begin
        bad++;
        $display("FAIL idle_hold[%0d] got v=%b sel=%0d data=%h want v=0 sel=3 data=b",
                 i, out_valid, out_sel, out_data);
      end
    end
    in_valid = 4'b0011;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL idle_resume_ready got=%b want=0001", in_ready); end
    step();
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin
      bad++; $display("FAIL idle_resume got v=%b sel=%0d data=%h want v=1 sel=0 data=1", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 4'b0100;
    step();
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2) begin
      bad++; $display("FAIL arst_pre got v=%b sel=%0d want v=1 sel=2", out_valid, out_sel);
    end
    in_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
      bad++; $display("FAIL arst_now got v=%b sel=%0d data=%h want v=0 sel=0 data=0", out_valid, out_sel, out_data);
    end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL arst_ready got=%b want=0000", in_ready); end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL arst_first_ready got=%b want=0001", in_ready); end
    step();
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
      bad++; $display("FAIL arst_first got v=%b sel=%0d want v=1 sel=0", out_valid, out_sel);
    end
  endtask

  task automatic test_two_lanes();
    logic [1:0] exp_sel [4];
`ifdef MUX_FIXED_PRIO_EN
    exp_sel = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_sel = '{2'd0, 2'd3, 2'd0, 2'd3};
`endif
    rst = 1'b1;
    #2;
    rst = 1'b0;
    in_valid = 4'b1001;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_ready !== (4'b0001 << exp_sel[i])) begin
        bad++; $display("FAIL two_ready[%0d] got=%b want=%b", i, in_ready, 4'b0001 << exp_sel[i]);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel[i]) begin
        bad++; $display("FAIL two_sel[%0d] got v=%b sel=%0d want v=1 sel=%0d", i, out_valid, out_sel, exp_sel[i]);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    in_data   = {4'hB, 4'h9, 4'h5, 4'h1};
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_lane();
    test_idle_hold();
    test_async_reset();
    test_two_lanes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
